// File: rtl/pid_sequencer.sv
// -----------------------------------------------------------------------------
// pid_sequencer
//   Steps a discrete PID update through an external 16-entry register bank.
//   Each busy cycle reads two bank entries, computes one result and writes it
//   back. Eight steps in total: error, P term, I term, D term, sum, PWM output,
//   and then the two history updates.
//
// Ports
//   clk      - single clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - sample request, honoured only in IDLE
//   OperaA   - bank read data for RtAddrs (signed Q8.10)
//   OperaB   - bank read data for RsAddrs (signed Q8.10)
//   RsAddrs  - read address feeding OperaB
//   RtAddrs  - read address feeding OperaA
//   RdAddrs  - write address
//   WtReg    - write enable; the bank captures WrDat at the closing edge
//   WrDat    - write data (signed Q8.10)
//   busy     - high during the eight compute steps
//   done     - one-cycle pulse after the last step
//   ovf      - set if any step saturated during the last sequence
// -----------------------------------------------------------------------------
module pid_sequencer #(
  parameter logic signed [17:0] KP = 18'sd1024,
  parameter logic signed [17:0] KI = 18'sd256,
  parameter logic signed [17:0] KD = 18'sd512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [17:0] OperaA,
  input  logic signed [17:0] OperaB,
  output logic        [3:0]  RsAddrs,
  output logic        [3:0]  RtAddrs,
  output logic        [3:0]  RdAddrs,
  output logic               WtReg,
  output logic signed [17:0] WrDat,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, DONE = 4'd9
  } state_t;

  // Per-state control word: the addresses and flags a state presents.
  typedef struct packed {
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
    logic       wt;
    logic       bsy;
    logic       dn;
  } dec_t;

  localparam dec_t DEC_IDLE = '{rs: 4'd0, rt: 4'd0, rd: 4'd0, wt: 1'b0, bsy: 1'b0, dn: 1'b0};
  localparam logic signed [25:0] W_MAX = 26'sd131071;
  localparam logic signed [25:0] W_MIN = 26'h3fe0000;   // -131072

  state_t state_r, state_s;
  dec_t   dec_r;
  logic   ovf_r, ovf_s;
  logic signed [17:0] wrdat_s;

  // Control word for a given state.
  function automatic dec_t decode(input state_t s);
    dec_t d;
    d = DEC_IDLE;
    case (s)
      S1:      d = '{rs: 4'd1, rt: 4'd2, rd: 4'd3,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S2:      d = '{rs: 4'd3, rt: 4'd0, rd: 4'd9,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S3:      d = '{rs: 4'd6, rt: 4'd3, rd: 4'd4,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S4:      d = '{rs: 4'd2, rt: 4'd5, rd: 4'd8,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S5:      d = '{rs: 4'd9, rt: 4'd4, rd: 4'd7,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S6:      d = '{rs: 4'd7, rt: 4'd8, rd: 4'd10, wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S7:      d = '{rs: 4'd4, rt: 4'd0, rd: 4'd6,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      S8:      d = '{rs: 4'd2, rt: 4'd0, rd: 4'd5,  wt: 1'b1, bsy: 1'b1, dn: 1'b0};
      DONE:    d = '{rs: 4'd0, rt: 4'd0, rd: 4'd0,  wt: 1'b0, bsy: 1'b0, dn: 1'b1};
      default: d = DEC_IDLE;
    endcase
    return d;
  endfunction

  // Sign-extended sum / difference; 26 bits so all operators share one saturator.
  function automatic logic signed [25:0] add_w(input logic signed [17:0] x, input logic signed [17:0] y);
    return {{8{x[17]}}, x} + {{8{y[17]}}, y};
  endfunction

  function automatic logic signed [25:0] sub_w(input logic signed [17:0] x, input logic signed [17:0] y);
    return {{8{x[17]}}, x} - {{8{y[17]}}, y};
  endfunction

  // Q8.10 product: full 36-bit product, drop the 10 fraction bits (floor).
  function automatic logic signed [25:0] mul_w(input logic signed [17:0] x, input logic signed [17:0] y);
    logic signed [35:0] p;
    p = 36'(x) * 36'(y);
    return p[35:10];
  endfunction

  function automatic logic signed [17:0] sat18(input logic signed [25:0] v);
    if (v > W_MAX) begin
      return 18'h1ffff;
    end else if (v < W_MIN) begin
      return 18'h20000;
    end else begin
      return v[17:0];
    end
  endfunction

  function automatic logic clipped(input logic signed [25:0] v);
    return (v > W_MAX) || (v < W_MIN);
  endfunction

  // Next state, write data and overflow flag for the current step.
  always_comb begin
    logic signed [25:0] mid_w;
    logic signed [25:0] res_w;
    logic signed [17:0] mid_q;
    state_s = state_r;
    wrdat_s = 18'sd0;
    ovf_s   = ovf_r;
    mid_w   = 26'sd0;
    res_w   = 26'sd0;
    mid_q   = 18'sd0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = S1;
          ovf_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      S1: begin
        res_w   = sub_w(OperaB, OperaA);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(res_w);
        state_s = S2;
      end
      S2: begin
        res_w   = mul_w(KP, OperaB);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(res_w);
        state_s = S3;
      end
      S3: begin
        // ik = ik1 + KI*ek, both stages saturate independently
        mid_w   = mul_w(KI, OperaA);
        mid_q   = sat18(mid_w);
        res_w   = add_w(OperaB, mid_q);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(mid_w) | clipped(res_w);
        state_s = S4;
      end
      S4: begin
        // dk = KD*(POT - yk1): derivative on measurement, not on error
        mid_w   = sub_w(OperaB, OperaA);
        mid_q   = sat18(mid_w);
        res_w   = mul_w(KD, mid_q);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(mid_w) | clipped(res_w);
        state_s = S5;
      end
      S5: begin
        res_w   = add_w(OperaB, OperaA);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(res_w);
        state_s = S6;
      end
      S6: begin
        res_w   = sub_w(OperaB, OperaA);
        wrdat_s = sat18(res_w);
        ovf_s   = ovf_r | clipped(res_w);
        state_s = S7;
      end
      S7: begin
        wrdat_s = OperaB;
        state_s = S8;
      end
      S8: begin
        wrdat_s = OperaB;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, registered control word and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      dec_r   <= DEC_IDLE;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      dec_r   <= decode(state_s);
      ovf_r   <= ovf_s;
    end
  end

  assign RsAddrs = dec_r.rs;
  assign RtAddrs = dec_r.rt;
  assign RdAddrs = dec_r.rd;
  assign WtReg   = dec_r.wt;
  assign busy    = dec_r.bsy;
  assign done    = dec_r.dn;
  assign ovf     = ovf_r;
  assign WrDat   = wrdat_s;

endmodule

// File: doc/pid_sequencer.md
PID_SEQUENCER -- requirements
Module: pid_sequencer

Interface
REQ-001 Parameter KP, default 18'sd1024, proportional gain, signed Q8.10 (1024 = 1.0).
REQ-002 Parameter KI, default 18'sd256, integral gain, signed Q8.10.
REQ-003 Parameter KD, default 18'sd512, derivative gain, signed Q8.10.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  sample request, sampled at rising edge.
REQ-007 OperaA  input  18  register-bank read data for address RtAddrs, signed Q8.10.
REQ-008 OperaB  input  18  register-bank read data for address RsAddrs, signed Q8.10.
REQ-009 RsAddrs  output  4  read address driving OperaB.
REQ-010 RtAddrs  output  4  read address driving OperaA.
REQ-011 RdAddrs  output  4  write address.
REQ-012 WtReg  output  1  write enable; bank captures WrDat at the rising edge ending the cycle.
REQ-013 WrDat  output  18  write data, signed Q8.10.
REQ-014 busy  output  1  high while in S1..S8.
REQ-015 done  output  1  one-cycle pulse after completing a sequence.
REQ-016 ovf  output  1  high if any step saturated in the last sequence.

Function
REQ-017 Address map: 0 zero, 1 REF, 2 POT, 3 v1 (ek), 4 a0 (ik), 5 a1 (yk1), 6 a2 (ik1), 7 a3 (temp2), 8 t0 (dk), 9 t1 (pk), 10 t2 (PWM); 11..15 never driven.
REQ-018 FSM states: IDLE, S1..S8, DONE; Moore decode, so addresses, WtReg and busy are functions of the state register only.
REQ-019 IDLE: Rs=Rt=Rd=0, WtReg=0; start=1 -> S1; otherwise stay.
REQ-020 S1: Rs=1, Rt=2, Rd=3, WrDat = sat(B - A) (ek = REF - POT).
REQ-021 S2: Rs=3, Rt=0, Rd=9, WrDat = mul(KP, B) (pk).
REQ-022 S3: Rs=6, Rt=3, Rd=4, WrDat = sat(B + mul(KI, A)) (ik = ik1 + KI*ek).
REQ-023 S4: Rs=2, Rt=5, Rd=8, WrDat = mul(KD, sat(B - A)) (dk = KD*(POT - yk1)).
REQ-024 S5: Rs=9, Rt=4, Rd=7, WrDat = sat(B + A) (temp2 = pk + ik).
REQ-025 S6: Rs=7, Rt=8, Rd=10, WrDat = sat(B - A) (PWM = temp2 - dk).
REQ-026 S7: Rs=4, Rt=0, Rd=6, WrDat = B (ik1 = ik).
REQ-027 S8: Rs=2, Rt=0, Rd=5, WrDat = B (yk1 = POT).
REQ-028 Each of S1..S8 lasts exactly one cycle with WtReg=1, then advances unconditionally; S8 -> DONE -> IDLE.
REQ-029 DONE: WtReg=0, all addresses 0, done=1 for exactly one cycle.
REQ-030 Latency: start sampled at edge k -> PWM written at edge k+6; done high in cycle after edge k+8; busy high for 8 cycles.
REQ-031 Add/sub: 19-bit signed intermediate, saturated to [-131072, 131071].
REQ-032 mul(x,y): 36-bit signed product, arithmetic shift right 10 (truncate), saturated to 18 bits.
REQ-033 ovf is cleared on the edge leaving IDLE and set on any saturating edge in S1..S8; it holds until the next start.
REQ-034 start while not in IDLE is ignored and never queued; start in DONE is ignored.
REQ-035 In IDLE and DONE, WrDat = 0.

Reset
REQ-036 rst=0 forces IDLE immediately, regardless of clk: RsAddrs=RtAddrs=RdAddrs=0, WtReg=0, WrDat=0, busy=0, done=0, ovf=0.
REQ-037 Reset mid-sequence abandons the sequence; partially written bank values are not rolled back; the first start after release begins at S1.

Verification
REQ-038 Assert rst=0 asynchronously mid-cycle -> all outputs 0 before the next edge, state IDLE.
REQ-039 Bank zeroed, REF=2048, POT=1024, default gains, start -> ek=1024, pk=1024, ik=256, dk=512, temp2=1280, PWM=768, ik1=256, yk1=1024, ovf=0, done at start+9 cycles.
REQ-040 Repeat REQ-039 without reset -> ik=512, dk=0, temp2=1536, PWM=1536, ik1=512.
REQ-041 REF=131071, POT=-131072 -> ek=131071 saturated, ovf=1 after sequence; next start with REF=POT=0 clears ovf to 0.
REQ-042 Pulse start during S3 -> ignored, exactly 8 WtReg cycles and one done pulse.
REQ-043 Reset asserted in S4, released, start -> sequence runs S1..S8 from scratch, PWM matches the model using the partially updated bank.
